// File: rtl/dm_lsu_pkg.sv
// dm_lsu_pkg: access-size and state types plus lane helpers for the data-memory load/store unit
package dm_lsu_pkg;
    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } size_e;

    typedef enum logic [1:0] {IDLE, RESP, HOLD} state_e;

    localparam int unsigned DM_WORDS_DEF = 3072;

    function automatic logic is_byte(input logic [2:0] size);
        return size == SZ_B || size == SZ_BU;
    endfunction

    function automatic logic is_half(input logic [2:0] size);
        return size == SZ_H || size == SZ_HU;
    endfunction

    // Sizes outside the byte/half classes, including unlisted codes, act as full words
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] off);
        return is_byte(size) ? 4'b0001 << off : is_half(size) ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction
endpackage

// File: rtl/dm_lsu_load_fmt.sv
// dm_lsu_load_fmt: selects the loaded lane from a RAM word and sign/zero-extends it
import dm_lsu_pkg::*;

module dm_lsu_load_fmt (
    input  logic [31:0] rdata,
    input  logic [2:0]  size,
    input  logic [1:0]  off,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        data = size == SZ_B  ? {{24{b[7]}}, b} :
               size == SZ_BU ? {24'b0, b} :
               size == SZ_H  ? {{16{h[15]}}, h} :
               size == SZ_HU ? {16'b0, h} : rdata;
    end
endmodule

// File: rtl/dm_lsu.sv
// dm_lsu: MEM-stage load/store unit; define DM_LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses
import dm_lsu_pkg::*;

module dm_lsu #(
    parameter int unsigned DM_WORDS = DM_WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic [11:0] dm_addr,
    output logic        dm_en,
    output logic [3:0]  dm_we,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
`ifdef DM_LSU_MISALIGN_TRAP_EN
    output logic        exc_valid,
    output logic [31:0] exc_addr,
    output logic        exc_store,
`endif
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);
    state_e      state, state_n;
    logic [4:0]  rd_q;
    logic [2:0]  size_q;
    logic [1:0]  off_q;
    logic        oor_q;
    logic [31:0] hold_q, fmt_data, resp_data;
    logic        acc, in_range, mis, ld_acc;

    dm_lsu_load_fmt u_fmt (
        .rdata (dm_rdata),
        .size  (size_q),
        .off   (off_q),
        .data  (fmt_data)
    );

    always_comb begin
        req_ready = state == IDLE || wb_ready;
        acc = req_valid && req_ready;
        in_range = req_addr[31:14] == '0 && 32'(req_addr[13:2]) < DM_WORDS;
`ifdef DM_LSU_MISALIGN_TRAP_EN
        mis = is_half(req_size) ? req_addr[0] : !is_byte(req_size) && req_addr[1:0] != 2'b00;
`else
        mis = 1'b0;
`endif
        dm_addr = req_addr[13:2];
        dm_en = rst_n && acc && in_range && !mis;
        dm_we = dm_en && req_we ? lane_mask(req_size, req_addr[1:0]) : 4'b0000;
        dm_wdata = is_byte(req_size) ? {4{req_wdata[7:0]}} : is_half(req_size) ? {2{req_wdata[15:0]}} : req_wdata;
        // Trapped and out-of-range loads differ: only the trap suppresses the response
        ld_acc = acc && !req_we && !mis;
        state_n = req_ready ? (ld_acc ? RESP : IDLE) : state == RESP ? HOLD : state;
        resp_data = oor_q ? '0 : fmt_data;
        wb_valid = state != IDLE;
        wb_data = state == RESP ? resp_data : state == HOLD ? hold_q : '0;
        wb_rd = rd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rd_q   <= '0;
            size_q <= '0;
            off_q  <= '0;
            oor_q  <= 1'b0;
            hold_q <= '0;
        end else begin
            state <= state_n;
            if (ld_acc) begin
                rd_q   <= req_rd;
                size_q <= req_size;
                off_q  <= req_addr[1:0];
                oor_q  <= !in_range;
            end
            if (state == RESP && !wb_ready) hold_q <= resp_data;
        end
    end

`ifdef DM_LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_valid <= 1'b0;
            exc_addr  <= '0;
            exc_store <= 1'b0;
        end else begin
            exc_valid <= acc && mis;
            if (acc && mis) begin
                exc_addr  <= req_addr;
                exc_store <= req_we;
            end
        end
    end
`endif
endmodule
